// File: rtl/pipe_sel_stage.sv
// pipe_sel_stage: N-way, W-bit source selector feeding a registered
// valid/ready pipeline stage.
//
// The entry stored with each word is {data, src, err}. M is the main
// register that drives the outputs. S is the skid register. S and the TWO
// state exist only when the build macro PIPE_SEL_SKID_EN is defined.
//
// Handshake rules:
// - A word moves on an edge where valid and ready are both high
//   (accept = in_valid & in_ready, pop = out_valid & out_ready).
// - A producer holds valid and its data until the word moves.
// - flush discards everything held, and voids any accept or pop in the same
//   cycle. The out_data, out_src and out_err fields keep their values.
// - With the skid register present, in_ready is a flop and has no
//   combinational path from out_ready. Without it, in_ready passes
//   out_ready through whenever M is full.
module pipe_sel_stage #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*W-1:0]       in_data,
  input  logic [$clog2(N)-1:0] in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_src,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           dbg_state
);

  localparam int SELW = $clog2(N);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    m_data_q, m_data_d;
  logic [SELW-1:0] m_src_q, m_src_d;
  logic            m_err_q, m_err_d;
  logic [W-1:0]    sel_data;
  logic            sel_err;
  logic            accept, pop;

  // Combinational channel select. An out-of-range select yields zero data.
  always_comb begin
    sel_data = '0;
    sel_err  = (32'(in_sel) >= N);
    for (int k = 0; k < N; k++) begin
      if (in_sel == SELW'(k)) sel_data = in_data[k*W +: W];
    end
  end

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = m_data_q;
  assign out_src   = m_src_q;
  assign out_err   = m_err_q;
  assign dbg_state = state_q;

`ifdef PIPE_SEL_SKID_EN
  logic [W-1:0]    s_data_q, s_data_d;
  logic [SELW-1:0] s_src_q, s_src_d;
  logic            s_err_q, s_err_d;
  logic            in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  // Next-state and register-load decisions for the EMPTY/ONE/TWO machine.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_src_d  = m_src_q;
    m_err_d  = m_err_q;
    s_data_d = s_data_q;
    s_src_d  = s_src_q;
    s_err_d  = s_err_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d  = ST_ONE;
          m_data_d = sel_data;
          m_src_d  = in_sel;
          m_err_d  = sel_err;
        end
        ST_ONE: begin
          if (accept && pop) begin
            m_data_d = sel_data;
            m_src_d  = in_sel;
            m_err_d  = sel_err;
          end else if (accept) begin
            state_d  = ST_TWO;
            s_data_d = sel_data;
            s_src_d  = in_sel;
            s_err_d  = sel_err;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: if (pop) begin
          state_d  = ST_ONE;
          m_data_d = s_data_q;
          m_src_d  = s_src_q;
          m_err_d  = s_err_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // Skid register and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_data_q   <= '0;
      s_src_q    <= '0;
      s_err_q    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      s_data_q   <= s_data_d;
      s_src_q    <= s_src_d;
      s_err_q    <= s_err_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  // Without a skid slot, M can take a new word only when it is empty or
  // being drained in the same cycle.
  assign in_ready = !out_valid | out_ready;

  // Next-state and M-load decisions for the EMPTY/ONE machine.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_src_d  = m_src_q;
    m_err_d  = m_err_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d  = ST_ONE;
      m_data_d = sel_data;
      m_src_d  = in_sel;
      m_err_d  = sel_err;
    end else if (pop) begin
      state_d = ST_EMPTY;
    end
  end
`endif

  // State and main register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      m_data_q <= '0;
      m_src_q  <= '0;
      m_err_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_src_q  <= m_src_d;
      m_err_q  <= m_err_d;
    end
  end

endmodule
